grant_scheduler4: RTL and testbench
===================================

GRANT_SCHEDULER4 -- requirements
Module: grant_scheduler4

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum number of consecutive cycles one grant may stay asserted; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 req  input  4  request lines; bit i is requester i, level-sensitive.
REQ-005 done  input  1  release pulse from the current grantee; sampled only in GRANT.
REQ-006 gnt  output  4  one-hot grant; equals the 2-to-4 decode of gnt_idx in GRANT, else 4'b0000.
REQ-007 gnt_idx  output  2  index of the current or most recent grantee.
REQ-008 busy  output  1  high in GRANT and RECOVER, low in IDLE.
REQ-009 timeout  output  1  single-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-010 The FSM shall have exactly three states: IDLE, GRANT and RECOVER.
REQ-011 In IDLE with req != 0, the winner shall be the first asserted bit searching upward from (last_idx+1) mod 4 with wrap-around, and the next state shall be GRANT.
REQ-012 In IDLE with req == 0, the block shall remain in IDLE, with gnt at 0 and last_idx unchanged.
REQ-013 Grant latency: req sampled in IDLE at edge N shall give gnt asserted after edge N, i.e. a 1-cycle latency.
REQ-014 On entry to GRANT, gnt_idx and last_idx shall load the winner index, and hold_cnt shall load 1.
REQ-015 In GRANT, hold_cnt shall increment by 1 each cycle; it is an 8-bit counter and shall never wrap, because exit occurs at MAX_HOLD.
REQ-016 GRANT shall release to RECOVER when done=1, or when req[gnt_idx]=0 (requester withdrew).
REQ-017 If no release occurs and hold_cnt == MAX_HOLD, GRANT shall go to RECOVER and timeout shall be 1 for exactly the next cycle.
REQ-018 If a release and the MAX_HOLD expiry occur in the same cycle, the release shall win and timeout shall stay 0.
REQ-019 Requests from non-granted requesters during GRANT shall be ignored; there is no preemption.
REQ-020 RECOVER shall last exactly one cycle with gnt=0 (bus turnaround), then the FSM shall go to IDLE unconditionally.
REQ-021 Back-to-back throughput: release sampled at edge M shall give gnt=0 after M, IDLE after M+1, and the earliest new grant after M+2.
REQ-022 gnt shall never have more than one bit set in any cycle.
REQ-023 A requester holding req continuously shall be granted again only after every other continuously requesting requester has been served once.
REQ-024 done asserted outside GRANT shall have no effect.

Reset
REQ-025 While rst_n=0, the block shall force state=IDLE, gnt=0, gnt_idx=0, busy=0, timeout=0, hold_cnt=0 and last_idx=3, so that requester 0 has first priority.
REQ-026 Asserting rst_n mid-GRANT shall drop gnt to 0 immediately, without waiting for a clock edge.
REQ-027 After rst_n deasserts, the first arbitration shall occur on the first rising edge that samples rst_n=1.

Verification
REQ-028 Scenario: after reset, req=4'b1111 held, done pulsed on each grant's 2nd cycle -> grant order 0,1,2,3,0, gnt values 0001,0010,0100,1000,0001, with 2 idle cycles between grants.
REQ-029 Scenario: req=4'b0100 held, done never asserted, MAX_HOLD=8 -> gnt=0100 for exactly 8 cycles, then timeout=1 for 1 cycle concurrent with RECOVER, then re-grant to 2.
REQ-030 Scenario: grant to 1, then req[1] drops on cycle 3 -> gnt=0 on the next cycle, and timeout stays 0.
REQ-031 Scenario: MAX_HOLD=4, done asserted on the cycle where hold_cnt=4 -> normal release with timeout=0.
REQ-032 Scenario: rst_n asserted mid-grant between clock edges -> gnt=0 and busy=0 asynchronously; after release, req=4'b1010 gives a grant to 1 first.
REQ-033 The bench shall check continuously that gnt is one-hot or zero, that gnt equals the decode of gnt_idx in GRANT, and that busy matches the state.

Source files
------------

// File: rtl/grant_scheduler4.sv
`default_nettype none
// ============================================================================
// Module      : grant_scheduler4
// Description : Four-requester round-robin grant scheduler with hold-time
//               limit, done/withdraw release and a one-cycle recovery gap.
// Revision    : 1.0 - initial release
// ============================================================================
module grant_scheduler4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic [1:0] last_idx_q, last_idx_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;

    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;
    logic       release_now;

    // Rotating search: first asserted request above the last grantee, wrapping.
    always_comb begin
        winner = last_idx_q + 2'd1;
        cand   = 2'd0;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = last_idx_q + 2'(k + 1);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign release_now = done || !req[gnt_idx_q];

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    state_d    = ST_GRANT;
                    gnt_idx_d  = winner;
                    last_idx_d = winner;
                    hold_cnt_d = 8'd1;
                end
            end
            ST_GRANT: begin
                // A voluntary release takes precedence over hold expiry.
                if (release_now) begin
                    state_d    = ST_RECOVER;
                    hold_cnt_d = 8'd0;
                end else if (hold_cnt_q == MAX_HOLD_C) begin
                    state_d    = ST_RECOVER;
                    hold_cnt_d = 8'd0;
                    timeout_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_idx_q  <= 2'd0;
            last_idx_q <= 2'd3;
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Decoded straight from state so an asynchronous reset clears it at once.
    assign gnt     = (state_q == ST_GRANT) ? (4'b0001 << gnt_idx_q) : 4'b0000;
    assign gnt_idx = gnt_idx_q;
    assign busy    = (state_q != ST_IDLE);
    assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_grant_scheduler4.sv
`default_nettype none
// ============================================================================
// Module      : tb_grant_scheduler4
// Description : Directed bench for grant_scheduler4 (MAX_HOLD 8 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grant_scheduler4;

    logic       clk;
    logic       rst_n, rst_n4;
    logic [3:0] req, req4;
    logic       done, done4;
    logic [3:0] gnt, gnt4;
    logic [1:0] gnt_idx, gnt_idx4;
    logic       busy, busy4;
    logic       timeout, timeout4;

    int n_cmp = 0;
    int n_err = 0;

    grant_scheduler4 #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout)
    );

    grant_scheduler4 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .req(req4), .done(done4),
        .gnt(gnt4), .gnt_idx(gnt_idx4), .busy(busy4), .timeout(timeout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Structural invariants on both instances, sampled away from the active edge.
    always @(negedge clk) begin
        chk("onehot", {7'd0, $onehot0(gnt)}, 8'd1);
        chk("onehot4", {7'd0, $onehot0(gnt4)}, 8'd1);
        if (gnt != 4'b0000) begin
            chk("decode", {4'd0, gnt}, {4'd0, 4'b0001 << gnt_idx});
            chk("busy_in_grant", {7'd0, busy}, 8'd1);
        end
        if (gnt4 != 4'b0000) begin
            chk("decode4", {4'd0, gnt4}, {4'd0, 4'b0001 << gnt_idx4});
            chk("busy_in_grant4", {7'd0, busy4}, 8'd1);
        end
        if (timeout) begin
            chk("timeout_gnt", {4'd0, gnt}, 8'd0);
            chk("timeout_busy", {7'd0, busy}, 8'd1);
        end
    end

    logic [3:0] exp_gnt [5];
    logic [1:0] exp_idx [5];

    initial begin
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst_n  = 1'b0;
        rst_n4 = 1'b0;
        req    = 4'b0000;
        done   = 1'b0;
        req4   = 4'b0000;
        done4  = 1'b0;

        #12;
        chk("rst_gnt", {4'd0, gnt}, 8'd0);
        chk("rst_idx", {6'd0, gnt_idx}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_timeout", {7'd0, timeout}, 8'd0);
        step;
        step;
        rst_n  = 1'b1;
        rst_n4 = 1'b1;
        req    = 4'b1111;

        // Round robin with done on each grant's second cycle.
        for (int k = 0; k < 5; k++) begin
            step;
            chk("rr_gnt_c1", {4'd0, gnt}, {4'd0, exp_gnt[k]});
            chk("rr_idx", {6'd0, gnt_idx}, {6'd0, exp_idx[k]});
            step;
            chk("rr_gnt_c2", {4'd0, gnt}, {4'd0, exp_gnt[k]});
            done = 1'b1;
            step;
            done = 1'b0;
            chk("rr_recover_gnt", {4'd0, gnt}, 8'd0);
            chk("rr_recover_busy", {7'd0, busy}, 8'd1);
            chk("rr_recover_to", {7'd0, timeout}, 8'd0);
            step;
            chk("rr_idle_gnt", {4'd0, gnt}, 8'd0);
            chk("rr_idle_busy", {7'd0, busy}, 8'd0);
        end
        req = 4'b0000;

        // Hold expiry at MAX_HOLD = 8.
        req = 4'b0100;
        step;
        for (int i = 0; i < 8; i++) begin
            chk("hold_gnt", {4'd0, gnt}, 8'h04);
            chk("hold_no_to", {7'd0, timeout}, 8'd0);
            step;
        end
        chk("expiry_timeout", {7'd0, timeout}, 8'd1);
        chk("expiry_gnt", {4'd0, gnt}, 8'd0);
        chk("expiry_busy", {7'd0, busy}, 8'd1);
        step;
        chk("expiry_idle_to", {7'd0, timeout}, 8'd0);
        chk("expiry_idle_busy", {7'd0, busy}, 8'd0);
        step;
        chk("regrant_gnt", {4'd0, gnt}, 8'h04);
        chk("regrant_idx", {6'd0, gnt_idx}, 8'd2);
        done = 1'b1;
        step;
        done = 1'b0;
        req  = 4'b0000;
        chk("regrant_rel_to", {7'd0, timeout}, 8'd0);
        chk("regrant_rel_gnt", {4'd0, gnt}, 8'd0);
        step;

        // Requester withdraws during its third grant cycle.
        req = 4'b0010;
        step;
        chk("wd_gnt", {4'd0, gnt}, 8'h02);
        chk("wd_idx", {6'd0, gnt_idx}, 8'd1);
        step;
        step;
        chk("wd_gnt_c3", {4'd0, gnt}, 8'h02);
        req = 4'b0000;
        step;
        chk("wd_drop_gnt", {4'd0, gnt}, 8'd0);
        chk("wd_drop_to", {7'd0, timeout}, 8'd0);
        chk("wd_drop_busy", {7'd0, busy}, 8'd1);
        step;

        // Rotation wraps past 3 to 0 after a grant to 1.
        req = 4'b0011;
        step;
        chk("wrap_gnt", {4'd0, gnt}, 8'h01);
        done = 1'b1;
        req  = 4'b0000;
        step;
        done = 1'b0;
        step;

        // done outside GRANT is ignored.
        done = 1'b1;
        step;
        chk("done_idle_busy", {7'd0, busy}, 8'd0);
        chk("done_idle_gnt", {4'd0, gnt}, 8'd0);
        req = 4'b1000;
        step;
        done = 1'b0;
        chk("done_idle_grant", {4'd0, gnt}, 8'h08);
        step;
        chk("done_idle_hold", {4'd0, gnt}, 8'h08);
        req = 4'b0000;
        step;
        step;

        // Asynchronous reset in the middle of a grant.
        req = 4'b0010;
        step;
        chk("pre_rst_gnt", {4'd0, gnt}, 8'h02);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", {4'd0, gnt}, 8'd0);
        chk("async_rst_busy", {7'd0, busy}, 8'd0);
        chk("async_rst_idx", {6'd0, gnt_idx}, 8'd0);
        req = 4'b1010;
        step;
        chk("rst_held_gnt", {4'd0, gnt}, 8'd0);
        rst_n = 1'b1;
        step;
        chk("post_rst_gnt", {4'd0, gnt}, 8'h02);
        chk("post_rst_idx", {6'd0, gnt_idx}, 8'd1);
        done = 1'b1;
        step;
        done = 1'b0;
        req  = 4'b0000;
        step;

        // MAX_HOLD = 4: done on the expiry cycle wins, then a real expiry.
        req4 = 4'b0001;
        step;
        chk("mh4_gnt_c1", {4'd0, gnt4}, 8'h01);
        step;
        step;
        step;
        chk("mh4_gnt_c4", {4'd0, gnt4}, 8'h01);
        done4 = 1'b1;
        step;
        done4 = 1'b0;
        chk("mh4_rel_to", {7'd0, timeout4}, 8'd0);
        chk("mh4_rel_gnt", {4'd0, gnt4}, 8'd0);
        step;
        step;
        chk("mh4_regrant", {4'd0, gnt4}, 8'h01);
        step;
        step;
        step;
        chk("mh4_last_hold", {4'd0, gnt4}, 8'h01);
        chk("mh4_last_to", {7'd0, timeout4}, 8'd0);
        step;
        chk("mh4_expiry_to", {7'd0, timeout4}, 8'd1);
        chk("mh4_expiry_gnt", {4'd0, gnt4}, 8'd0);
        req4 = 4'b0000;
        step;
        chk("mh4_to_pulse", {7'd0, timeout4}, 8'd0);
        step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
